// File: rtl/bisr_repair_ctrl.sv
// BISR repair controller: gathers per-PE fault reports and maps the single redundant MAC onto a faulty PE.
// Optional macro BISR_STICKY_FAULT_EN keeps the fault map across re-runs, so only rst clears it.
module bisr_repair_ctrl #(
  parameter int ROWS          = 2,
  parameter int COLS          = 2,
  parameter int SETTLE_CYCLES = 4,
  localparam int NPE = ROWS * COLS,
  localparam int IW  = (NPE > 1) ? $clog2(NPE) : 1,
  localparam int CW  = $clog2(NPE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rpt_valid,
  output logic          rpt_ready,
  input  logic [IW-1:0] rpt_pe_idx,
  input  logic          rpt_fail,
  input  logic          scan_done,
  output logic [NPE-1:0] repair_map,
  output logic          spare_en,
  output logic [IW-1:0] spare_sel_idx,
  output logic [CW-1:0] fault_count,
  output logic          repair_done,
  output logic          unrepairable
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ALLOC,
    ST_APPLY,
    ST_DONE,
    ST_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [NPE-1:0]  fault_map_q, fault_map_d;
  logic [3:0]      settle_q, settle_d;
  logic            rpt_ready_d;
  logic [NPE-1:0]  repair_map_d;
  logic            spare_en_d;
  logic [IW-1:0]   spare_sel_d;
  logic [CW-1:0]   fault_count_d;
  logic            repair_done_d;
  logic            unrepairable_d;
  logic [IW-1:0]   low_idx;
  logic            rpt_idx_ok;
  logic            begin_run;

  assign rpt_idx_ok = (32'(rpt_pe_idx) < NPE);
  assign begin_run  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_FAIL);

  // Lowest set bit; only consulted when exactly one bit is set.
  always_comb begin
    low_idx = '0;
    for (int i = NPE - 1; i >= 0; i--) begin
      if (fault_map_q[i]) low_idx = IW'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    fault_map_d    = fault_map_q;
    settle_d       = settle_q;
    rpt_ready_d    = rpt_ready;
    repair_map_d   = repair_map;
    spare_en_d     = spare_en;
    spare_sel_d    = spare_sel_idx;
    fault_count_d  = fault_count;
    repair_done_d  = repair_done;
    unrepairable_d = unrepairable;

    case (state_q)
      ST_COLLECT: begin
        if (rpt_valid && rpt_ready && rpt_fail && rpt_idx_ok && !fault_map_q[rpt_pe_idx]) begin
          fault_map_d[rpt_pe_idx] = 1'b1;
          if (fault_count < CW'(NPE)) fault_count_d = fault_count + CW'(1);
        end
        if (scan_done) begin
          state_d     = ST_ALLOC;
          rpt_ready_d = 1'b0;
        end
      end
      ST_ALLOC: begin
        if (fault_count == '0) begin
          state_d       = ST_DONE;
          spare_en_d    = 1'b0;
          repair_done_d = 1'b1;
        end else if (fault_count == CW'(1)) begin
          state_d      = ST_APPLY;
          spare_sel_d  = low_idx;
          repair_map_d = fault_map_q;
          spare_en_d   = 1'b1;
          settle_d     = 4'(SETTLE_CYCLES);
        end else begin
          state_d        = ST_FAIL;
          unrepairable_d = 1'b1;
          spare_en_d     = 1'b0;
          repair_map_d   = '0;
        end
      end
      ST_APPLY: begin
        if (settle_q == 4'd0) begin
          state_d       = ST_DONE;
          repair_done_d = 1'b1;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: ;
    endcase

    // A new run drops the previous repair configuration before collecting.
    if (begin_run) begin
      state_d        = ST_COLLECT;
      rpt_ready_d    = 1'b1;
      repair_map_d   = '0;
      spare_en_d     = 1'b0;
      spare_sel_d    = '0;
      repair_done_d  = 1'b0;
      unrepairable_d = 1'b0;
`ifdef BISR_STICKY_FAULT_EN
      fault_map_d    = fault_map_q;
      fault_count_d  = fault_count;
`else
      fault_map_d    = '0;
      fault_count_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fault_map_q   <= '0;
      settle_q      <= '0;
      rpt_ready     <= 1'b0;
      repair_map    <= '0;
      spare_en      <= 1'b0;
      spare_sel_idx <= '0;
      fault_count   <= '0;
      repair_done   <= 1'b0;
      unrepairable  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fault_map_q   <= fault_map_d;
      settle_q      <= settle_d;
      rpt_ready     <= rpt_ready_d;
      repair_map    <= repair_map_d;
      spare_en      <= spare_en_d;
      spare_sel_idx <= spare_sel_d;
      fault_count   <= fault_count_d;
      repair_done   <= repair_done_d;
      unrepairable  <= unrepairable_d;
    end
  end

endmodule
